// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver
//   Receives PS/2 keyboard frames (start, 8 data bits LSB first, parity,
//   stop) and turns scancodes into a held-key value plus event pulses.
//   The F0 (break) and E0 (extended) prefixes are tracked as flags.
//   If the PS/2 clock stalls inside a frame for TIMEOUT_CYCLES system
//   clocks, the partial frame is dropped.
//
//   Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad
//   odd parity. When it is undefined, the parity bit is sampled and ignored.
//
// Ports
//   clock        system clock; all state changes on its rising edge
//   reset        synchronous, active-high
//   ps2_clk      raw PS/2 clock, asynchronous
//   ps2_dat      raw PS/2 data, asynchronous
//   key[7:0]     scancode of the held key, 8'h00 when no key is held
//   key_valid    1-cycle pulse when key is loaded with a make code
//   key_release  1-cycle pulse when an F0 xx break sequence completes
//   frame_err    1-cycle pulse on a stop, parity or timeout error
module ps2_key_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       key_release,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic [7:0]  shift_q, shift_d, key_q, key_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        par_q, par_d, brk_q, brk_d, ext_q, ext_d;
    logic        valid_q, valid_d, rel_q, rel_d, err_q, err_d;
    logic        fall, tmo_hit, byte_ok;

    // clk_prev_q holds the previous synchronized clock; a 1->0 step is a
    // falling edge, detected 3 system clocks after the raw edge.
    assign fall    = clk_prev_q & ~clk_s2_q;
    // The counter reaches TIMEOUT_CYCLES on this cycle. This test ignores
    // the edge, so a coinciding falling edge loses to the timeout.
    assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_LAST);

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: the 8 data bits plus the parity bit must contain an odd
    // number of ones.
    assign byte_ok = dat_s2_q & (^{shift_q, par_q});
`else
    assign byte_ok = dat_s2_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= '0;
            key_q      <= '0;
            bcnt_q     <= '0;
            tmo_q      <= '0;
            par_q      <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            rel_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_dat;
            dat_s2_q   <= dat_s1_q;
            state_q    <= state_d;
            shift_q    <= shift_d;
            key_q      <= key_d;
            bcnt_q     <= bcnt_d;
            tmo_q      <= tmo_d;
            par_q      <= par_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            rel_q      <= rel_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        key_d   = key_q;
        bcnt_d  = bcnt_q;
        par_d   = par_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        valid_d = 1'b0;
        rel_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = (state_q == IDLE || fall) ? 16'd0 : tmo_q + 16'd1;

        if (tmo_hit) begin
            state_d = IDLE;
            err_d   = 1'b1;
            shift_d = '0;
            bcnt_d  = '0;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
            tmo_d   = '0;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    // A 1 here is line noise or idle, not a start bit.
                    if (!dat_s2_q) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                        shift_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bcnt_q == 3'd7) state_d = PARITY;
                    else                bcnt_d  = bcnt_q + 3'd1;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!byte_ok) begin
                        err_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else begin
                        ext_d = 1'b0;
                        if (brk_q) begin
                            rel_d = 1'b1;
                            brk_d = 1'b0;
                            // Releasing a key other than the held one leaves
                            // the held key in place.
                            if (shift_q == key_q) key_d = 8'h00;
                        end else begin
                            key_d   = shift_q;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign key         = key_q;
    assign key_valid   = valid_q;
    assign key_release = rel_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
module tb_ps2_key_receiver;
    localparam int TMO  = 200;
    localparam int HALF = 10;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] key;
    logic       key_valid, key_release, frame_err;

    int n_chk = 0, n_err = 0;
    int n_v = 0, n_r = 0, n_e = 0, n_excl = 0, n_wid = 0;
    logic pv = 1'b0, pr = 1'b0, pe = 1'b0;

    // Byte-level reference state
    logic [7:0] m_key = 8'h00;
    bit         m_brk = 1'b0, m_ext = 1'b0;

    ps2_key_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .key(key), .key_valid(key_valid), .key_release(key_release),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clock) begin
        n_v <= n_v + int'(key_valid);
        n_r <= n_r + int'(key_release);
        n_e <= n_e + int'(frame_err);
        if (int'(key_valid) + int'(key_release) + int'(frame_err) > 1)
            n_excl <= n_excl + 1;
        if ((key_valid && pv) || (key_release && pr) || (frame_err && pe))
            n_wid <= n_wid + 1;
        pv <= key_valid;
        pr <= key_release;
        pe <= frame_err;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit par_ok, input bit stop_b,
                         input string tag);
        int sv, sr, se;
        int ev, er, ee;
        sv = n_v; sr = n_r; se = n_e;
        ev = 0; er = 0; ee = 0;
        if (!stop_b || (PCHK && !par_ok)) ee = 1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            m_ext = 1'b0;
            if (m_brk) begin
                er = 1;
                m_brk = 1'b0;
                if (b == m_key) m_key = 8'h00;
            end else begin
                ev = 1;
                m_key = b;
            end
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_ok ? ~^b : ^b);
        ps2_bit(stop_b);
        wait_cyc(10);
        chk({tag, ".valid"}, n_v - sv, ev);
        chk({tag, ".release"}, n_r - sr, er);
        chk({tag, ".err"}, n_e - se, ee);
        chk({tag, ".key"}, int'(key), int'(m_key));
    endtask

    initial begin
        int sv, sr, se;
        logic [7:0] b;
        wait_cyc(4);
        chk("rst.key", int'(key), 0);
        chk("rst.valid", int'(key_valid), 0);
        chk("rst.release", int'(key_release), 0);
        chk("rst.err", int'(frame_err), 0);
        reset = 1'b0;
        wait_cyc(5);

        frame(8'h1D, 1, 1, "make1D");
        frame(8'h1D, 1, 1, "typematic1D");
        frame(8'hF0, 1, 1, "brk");
        frame(8'h1D, 1, 1, "rel1D");
        frame(8'h1D, 1, 1, "make1D_b");
        frame(8'hF0, 1, 1, "brk_b");
        frame(8'h1C, 1, 1, "rel1C");
        frame(8'h23, 0, 1, "badpar23");
        frame(8'h44, 1, 0, "badstop");
        frame(8'hE0, 1, 1, "ext");
        frame(8'h75, 1, 1, "ext75");

        // Break prefix then a stalled frame: timeout must also drop the flag.
        frame(8'hF0, 1, 1, "brk_pre_tmo");
        sv = n_v; sr = n_r; se = n_e;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        wait_cyc(TMO + 40);
        m_brk = 1'b0; m_ext = 1'b0;
        chk("tmo.err", n_e - se, 1);
        chk("tmo.valid", n_v - sv, 0);
        chk("tmo.release", n_r - sr, 0);
        chk("tmo.key", int'(key), int'(m_key));
        frame(8'h1B, 1, 1, "post_tmo1B");

        // Reset in the middle of a frame.
        sv = n_v; sr = n_r; se = n_e;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(3);
        m_key = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
        chk("midrst.pulses", (n_v - sv) + (n_r - sr) + (n_e - se), 0);
        chk("midrst.key", int'(key), 0);
        frame(8'h1C, 1, 1, "post_rst1C");

        // Random frames with prefixes, repeats and injected errors.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2)       b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else if (r == 3) b = m_key;
            else             b = 8'($urandom_range(0, 255));
            frame(b, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                  $sformatf("rnd%0d", n));
        end

        chk("exclusive", n_excl, 0);
        chk("width", n_wid, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
